mac_age_table: RTL
==================

# mac_age_table

Parametrised MAC learning table with hardware aging. It is the successor to the switch's basic address table. Ingress learns source addresses; egress looks up destination addresses and receives a registered port result one cycle later. Each entry carries an age counter that a background sweep decrements, so stale stations expire. The block adds station-move handling, oldest-entry replacement, per-port and global flush, and an occupancy count.

## Interface
Parameters:
- NUM_PORTS, 4, switch port count; PORT_W = $clog2(NUM_PORTS)
- NUM_ENTRIES, 16, table depth, power of two ≥ 2; IDX_W = $clog2(NUM_ENTRIES)
- ADDR_W, 48, MAC address width
- AGE_W, 4, age counter width; AGE_MAX = 2**AGE_W-1
- TICK_CYCLES, 1024, clk cycles between aging sweeps, ≥ NUM_ENTRIES+1

Ports:
- clk  in  1  single clock, all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- learn_req_i  in  1  learn strobe, one cycle per request
- learn_address_i  in  ADDR_W  source MAC address
- learn_port_i  in  PORT_W  ingress port
- read_req_i  in  1  lookup strobe
- read_address_i  in  ADDR_W  destination MAC address
- read_valid_o  out  1  lookup response strobe
- read_hit_o  out  1  address found, qualified by read_valid_o
- read_port_o  out  PORT_W  port of hit entry; 0 on miss
- flush_req_i  in  1  flush strobe
- flush_all_i  in  1  with flush_req_i: clear every entry
- flush_port_i  in  PORT_W  with flush_req_i, !flush_all_i: clear entries on this port
- entries_o  out  $clog2(NUM_ENTRIES+1)  count of valid entries
- sweep_busy_o  out  1  aging sweep in progress

## Operation
- Entry fields: valid, addr, port, age. Only valid entries match. Addresses are unique among valid entries.
- Learn, address matches a valid entry:
  - Same port: age := AGE_MAX.
  - Different port (station move): port := learn_port_i, age := AGE_MAX, in place. No duplicate entry is created.
- Learn, no match: write {1, addr, port, AGE_MAX} into a victim entry.
  - Victim = lowest-index invalid entry.
  - If the table is full, victim = valid entry with the smallest age; ties go to the lowest index.
- Lookup: match read_address_i against the current (pre-update) table and register the result. Lookup never refreshes age.
- Aging FSM states: IDLE, SWEEP.
  - Prescaler counts 0..TICK_CYCLES-1 and wraps. At wrap in IDLE: go to SWEEP with ptr := 0.
  - SWEEP, each cycle: if entry[ptr] is valid, age decrements. If age was 1, the entry becomes invalid (age 0). Then ptr increments.
  - When ptr = NUM_ENTRIES-1 is processed, return to IDLE. The prescaler keeps running during SWEEP.
- Flush clears the valid bit of all selected entries in one cycle.
- entries_o is recomputed as a registered popcount of valid bits.
- Same-cycle priority:
  - flush > learn > sweep on the same entry.
  - A learn that refreshes or writes entry[ptr] suppresses that sweep decrement.
  - Flush together with learn: flush applies, the learn is dropped.
  - Learn and lookup of the same address in one cycle: the lookup reports the pre-learn state.
- Victim selection, match and popcount are combinational over all entries. Table state is flops, not RAM.

## Timing
- Reset values: all entries invalid, ages 0, prescaler 0, FSM IDLE, ptr 0. All outputs 0.
- Reset asserted mid-sweep or mid-lookup aborts immediately to the reset values. No response is issued.
- Lookup latency is 1 cycle: read_req_i at cycle N gives read_valid_o=1 at N+1 for one cycle. Back-to-back requests give back-to-back responses.
- Learn and flush take effect at the next edge; they are visible to a lookup issued at N+1.
- entries_o reflects table state one cycle after the change (2 edges after the request).
- sweep_busy_o is 1 exactly in SWEEP: NUM_ENTRIES cycles, starting the cycle after the prescaler wrap.
- An entry untouched since its last learn expires after between AGE_MAX-1 and AGE_MAX tick periods.

## Structure
- Package mac_table_pkg holds:
  - the age_state_e enum (IDLE, SWEEP)
  - the mac_entry_t struct parametrised by widths, or per-field typedefs where the tool needs them
  - helper functions: lowest-free index and oldest-entry index
- One sub-module, mac_age_sweeper: prescaler, FSM, ptr. It outputs sweep_en and sweep_idx to the table core.

## Test plan
Benches use TICK_CYCLES=32 and AGE_W=2.
- Learn 00:11:22:33:44:55 on port 2, then look up the same address at N+1 → at N+2, read_valid_o=1, read_hit_o=1, read_port_o=2. Then entries_o=1.
- Learn the same address on port 3 → entries_o stays 1 and a lookup returns port 3 (station move, no duplicate).
- Fill all 16 entries. Learn one entry again just before a sweep so it has the highest age, leaving the others older. Learn a 17th address → it lands in the lowest-index oldest entry. entries_o=16 and the re-learned address still hits.
- Learn once, then idle 3 full tick periods → the entry is invalid. The lookup misses with read_port_o=0 and entries_o=0.
- Learn on ports 0,1,1,2, then flush_req_i with flush_port_i=1 → entries_o=2 and port-1 addresses miss. flush_all_i → entries_o=0.
- Learn the address held at entry[ptr] during SWEEP → its age is AGE_MAX, not AGE_MAX-1. Assert rst_n low mid-sweep → sweep_busy_o=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/mac_age_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mac_table_pkg
// Brief    : Shared types and victim-selection helpers for the MAC age table.
// Revision : 1.0  initial release
// ============================================================================
package mac_table_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } age_state_e;

    // Helpers take fixed-size vectors so they can live here; callers zero-pad.
    localparam int c_max_entries = 64;
    localparam int c_max_age_w   = 8;

    typedef logic [c_max_entries-1:0]                  valid_vec_t;
    typedef logic [c_max_entries-1:0][c_max_age_w-1:0] age_vec_t;

    function automatic int lowest_free(input valid_vec_t valid, input int n);
        int  idx;
        bit  found;
        idx   = 0;
        found = 1'b0;
        for (int i = 0; i < c_max_entries; i++) begin
            if (i < n && !found && !valid[i]) begin
                idx   = i;
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    function automatic int oldest_entry(input age_vec_t ages, input int n);
        int                     idx;
        logic [c_max_age_w-1:0] best;
        idx  = 0;
        best = ages[0];
        for (int i = 1; i < c_max_entries; i++) begin
            if (i < n && ages[i] < best) begin
                idx  = i;
                best = ages[i];
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_age_table_if.sv
`default_nettype none
// ============================================================================
// Module   : mac_age_table_if
// Brief    : Learn / lookup / flush / status bundle of the MAC age table.
// Revision : 1.0  initial release
// ============================================================================
interface mac_age_table_if #(
    parameter int NUM_PORTS   = 4,
    parameter int NUM_ENTRIES = 16,
    parameter int ADDR_W      = 48
);
    localparam int c_port_w = $clog2(NUM_PORTS);
    localparam int c_cnt_w  = $clog2(NUM_ENTRIES + 1);

    logic                learn_req_i;
    logic [ADDR_W-1:0]   learn_address_i;
    logic [c_port_w-1:0] learn_port_i;
    logic                read_req_i;
    logic [ADDR_W-1:0]   read_address_i;
    logic                read_valid_o;
    logic                read_hit_o;
    logic [c_port_w-1:0] read_port_o;
    logic                flush_req_i;
    logic                flush_all_i;
    logic [c_port_w-1:0] flush_port_i;
    logic [c_cnt_w-1:0]  entries_o;
    logic                sweep_busy_o;

    modport master (
        output learn_req_i, learn_address_i, learn_port_i,
        output read_req_i, read_address_i,
        output flush_req_i, flush_all_i, flush_port_i,
        input  read_valid_o, read_hit_o, read_port_o, entries_o, sweep_busy_o
    );

    modport slave (
        input  learn_req_i, learn_address_i, learn_port_i,
        input  read_req_i, read_address_i,
        input  flush_req_i, flush_all_i, flush_port_i,
        output read_valid_o, read_hit_o, read_port_o, entries_o, sweep_busy_o
    );
endinterface
`default_nettype wire

// File: rtl/mac_age_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module   : mac_age_sweeper
// Brief    : Tick prescaler and aging-sweep FSM walking every table entry.
// Revision : 1.0  initial release
// ============================================================================
module mac_age_sweeper
    import mac_table_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int TICK_CYCLES = 1024,
    parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    output logic                  sweep_en,
    output logic [IDX_W-1:0]      sweep_idx
);
    localparam int               c_pre_w   = $clog2(TICK_CYCLES);
    localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_CYCLES - 1);
    localparam logic [c_pre_w-1:0] c_pre_one  = c_pre_w'(1);
    localparam logic [IDX_W-1:0]   c_ptr_last = IDX_W'(NUM_ENTRIES - 1);
    localparam logic [IDX_W-1:0]   c_ptr_one  = IDX_W'(1);

    logic [c_pre_w-1:0] r_prescale;
    logic [IDX_W-1:0]   r_ptr;
    age_state_e         r_state;
    logic               w_wrap;

    assign w_wrap = (r_prescale == c_pre_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescale <= '0;
            r_ptr      <= '0;
            r_state    <= IDLE;
        end else begin
            r_prescale <= w_wrap ? '0 : r_prescale + c_pre_one;
            if (r_state == IDLE) begin
                if (w_wrap) begin
                    r_state <= SWEEP;
                    r_ptr   <= '0;
                end
            end else begin
                // Table depth is a power of two, so the pointer wraps back to 0 by itself.
                r_ptr <= r_ptr + c_ptr_one;
                if (r_ptr == c_ptr_last) begin
                    r_state <= IDLE;
                end
            end
        end
    end

    assign sweep_en  = (r_state == SWEEP);
    assign sweep_idx = r_ptr;

endmodule
`default_nettype wire

// File: rtl/mac_age_table.sv
`default_nettype none
// ============================================================================
// Module   : mac_age_table
// Brief    : Flop-based MAC learning table with aging, station move and flush.
// Revision : 1.0  initial release
// ============================================================================
module mac_age_table
    import mac_table_pkg::*;
#(
    parameter int NUM_PORTS   = 4,
    parameter int NUM_ENTRIES = 16,
    parameter int ADDR_W      = 48,
    parameter int AGE_W       = 4,
    parameter int TICK_CYCLES = 1024
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    mac_age_table_if.slave bus
);
    localparam int c_port_w = $clog2(NUM_PORTS);
    localparam int c_idx_w  = $clog2(NUM_ENTRIES);
    localparam int c_cnt_w  = $clog2(NUM_ENTRIES + 1);
    localparam logic [AGE_W-1:0] c_age_max = '1;
    localparam logic [AGE_W-1:0] c_age_one = AGE_W'(1);

    typedef logic [ADDR_W-1:0]   mac_addr_t;
    typedef logic [c_port_w-1:0] mac_port_t;
    typedef logic [AGE_W-1:0]    mac_age_t;
    typedef logic [c_idx_w-1:0]  mac_idx_t;

    logic [NUM_ENTRIES-1:0] r_valid;
    mac_addr_t              r_addr [NUM_ENTRIES];
    mac_port_t              r_port [NUM_ENTRIES];
    mac_age_t               r_age  [NUM_ENTRIES];

    logic                r_read_valid;
    logic                r_read_hit;
    mac_port_t           r_read_port;
    logic [c_cnt_w-1:0]  r_entries;

    logic                w_sweep_en;
    mac_idx_t            w_sweep_idx;
    logic                w_learn_en;
    logic                w_learn_hit;
    mac_idx_t            w_learn_hit_idx;
    mac_idx_t            w_learn_idx;
    logic                w_read_hit;
    mac_port_t           w_read_port;
    logic [c_cnt_w-1:0]  w_count;
    valid_vec_t          w_valid_pk;
    age_vec_t            w_age_pk;

    mac_age_sweeper #(
        .NUM_ENTRIES (NUM_ENTRIES),
        .TICK_CYCLES (TICK_CYCLES),
        .IDX_W       (c_idx_w)
    ) u_sweeper (
        .clk       (clk),
        .rst_n     (rst_n),
        .sweep_en  (w_sweep_en),
        .sweep_idx (w_sweep_idx)
    );

    // A flush in the same cycle drops the learn entirely.
    assign w_learn_en = bus.learn_req_i && !bus.flush_req_i;

    always_comb begin
        w_learn_hit     = 1'b0;
        w_learn_hit_idx = '0;
        w_read_hit      = 1'b0;
        w_read_port     = '0;
        w_count         = '0;
        w_valid_pk      = '0;
        w_age_pk        = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (r_valid[i] && r_addr[i] == bus.learn_address_i) begin
                w_learn_hit     = 1'b1;
                w_learn_hit_idx = c_idx_w'(i);
            end
            if (r_valid[i] && r_addr[i] == bus.read_address_i) begin
                w_read_hit  = 1'b1;
                w_read_port = r_port[i];
            end
            w_count       = w_count + c_cnt_w'(r_valid[i]);
            w_valid_pk[i] = r_valid[i];
            w_age_pk[i]   = c_max_age_w'(r_age[i]);
        end
        if (w_learn_hit) begin
            w_learn_idx = w_learn_hit_idx;
        end else if (!(&r_valid)) begin
            w_learn_idx = c_idx_w'(lowest_free(w_valid_pk, NUM_ENTRIES));
        end else begin
            w_learn_idx = c_idx_w'(oldest_entry(w_age_pk, NUM_ENTRIES));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                r_addr[i] <= '0;
                r_port[i] <= '0;
                r_age[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (bus.flush_req_i && r_valid[i] &&
                    (bus.flush_all_i || r_port[i] == bus.flush_port_i)) begin
                    r_valid[i] <= 1'b0;
                end else if (w_learn_en && w_learn_idx == c_idx_w'(i)) begin
                    r_valid[i] <= 1'b1;
                    r_addr[i]  <= bus.learn_address_i;
                    r_port[i]  <= bus.learn_port_i;
                    r_age[i]   <= c_age_max;
                end else if (w_sweep_en && w_sweep_idx == c_idx_w'(i) && r_valid[i]) begin
                    r_age[i] <= r_age[i] - c_age_one;
                    if (r_age[i] == c_age_one) begin
                        r_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_read_valid <= 1'b0;
            r_read_hit   <= 1'b0;
            r_read_port  <= '0;
            r_entries    <= '0;
        end else begin
            r_read_valid <= bus.read_req_i;
            r_read_hit   <= bus.read_req_i && w_read_hit;
            r_read_port  <= (bus.read_req_i && w_read_hit) ? w_read_port : '0;
            r_entries    <= w_count;
        end
    end

    assign bus.read_valid_o = r_read_valid;
    assign bus.read_hit_o   = r_read_hit;
    assign bus.read_port_o  = r_read_port;
    assign bus.entries_o    = r_entries;
    assign bus.sweep_busy_o = w_sweep_en;

endmodule
`default_nettype wire
